instruction_fetcher: RTL and testbench

//  Upstream client of the memory controller's fetch port. Owns the PC and a direct-mapped,
//  one-word-per-line instruction cache, and supplies one instruction per cycle on a hit to the

---
 rtl/instruction_fetcher_pkg.sv | 24 ++
 rtl/instruction_fetcher_icache_array.sv | 54 +++++
 rtl/instruction_fetcher.sv | 116 +++++++++++
 tb/tb_instruction_fetcher.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher and its cache.
package instruction_fetcher_pkg;

  localparam int ICACHE_INDEX_BITS = 6;
  localparam int IF_ADDR_RANGE     = 17;

  // Fetch FSM: lookup, or a miss outstanding at the memory controller.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } if_state_e;

  // One delivered instruction as presented to the instruction queue.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

  // Sequential successor; wraps modulo 2**32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetcher_icache_array.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Combinational lookup, single synchronous write port, synchronous valid clear.
import instruction_fetcher_pkg::*;

module icache_array #(
  parameter int ADDR_WIDTH = IF_ADDR_RANGE,
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:2] raddr_i,
  output logic                  hit_o,
  output logic [31:0]           rdata_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:2] waddr_i,
  input  logic [31:0]           wdata_i
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - 2 - INDEX_BITS;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [INDEX_BITS-1:0] ridx, widx;
  logic [TAG_W-1:0]      rtag, wtag;

  assign ridx = raddr_i[INDEX_BITS+1:2];
  assign rtag = raddr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign widx = waddr_i[INDEX_BITS+1:2];
  assign wtag = waddr_i[ADDR_WIDTH-1:INDEX_BITS+2];

  assign hit_o   = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign rdata_o = data_q[ridx];

  // Valid bits: cleared by reset, set by a refill.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; a refill overwrites whatever was there.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata_i;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: owns the PC, looks it up in a direct-mapped icache,
// delivers one instruction per cycle on hits and refills from the memory
// controller on misses. A ROB clear redirects the PC at any time; an
// outstanding fetch still completes and fills its line but is never delivered.
import instruction_fetcher_pkg::*;

module instruction_fetcher #(
  parameter int          ADDR_WIDTH = IF_ADDR_RANGE,
  parameter int          INDEX_BITS = ICACHE_INDEX_BITS,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mc_fetch_start,
  output logic [31:0] mc_pc,
  input  logic        mc_finish_fetch,
  input  logic [31:0] mc_instruction,
  input  logic        iq_full,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        discard_q;
  logic        iq_valid_q;
  iq_entry_t   iq_q;

  logic        hit;
  logic [31:0] rdata;
  logic        refill_we;

  // Refill lands whenever the controller finishes, even under a ROB clear:
  // the address was correct, only the delivery is dropped.
  assign refill_we = rst_in && rdy_in && (state_q == S_WAIT) && mc_finish_fetch;

  icache_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_icache (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .raddr_i (pc_q[ADDR_WIDTH-1:2]),
    .hit_o   (hit),
    .rdata_o (rdata),
    .we_i    (refill_we),
    .waddr_i (req_pc_q[ADDR_WIDTH-1:2]),
    .wdata_i (mc_instruction)
  );

  // Request stays up until the finish pulse so a busy controller sees it later.
  assign mc_fetch_start = (state_q == S_WAIT) && !mc_finish_fetch;
  assign mc_pc          = req_pc_q;

  assign iq_valid = iq_valid_q;
  assign iq_inst  = iq_q.inst;
  assign iq_pc    = iq_q.pc;

  // PC, fetch FSM, discard flag and registered queue outputs; frozen while !rdy_in.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      state_q    <= S_IDLE;
      discard_q  <= 1'b0;
      iq_valid_q <= 1'b0;
      iq_q       <= '0;
    end else if (rdy_in) begin
      iq_valid_q <= 1'b0;
      if (rob_clear) begin
        pc_q <= rob_clear_pc;
        if (state_q == S_WAIT) begin
          if (mc_finish_fetch) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
          end else begin
            discard_q <= 1'b1;
          end
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!hit) begin
              // Misses go out regardless of queue space.
              req_pc_q <= {pc_q[31:2], 2'b00};
              state_q  <= S_WAIT;
            end else if (!iq_full) begin
              iq_valid_q <= 1'b1;
              iq_q.inst  <= rdata;
              iq_q.pc    <= pc_q;
              pc_q       <= pc_next(pc_q);
            end
          end
          S_WAIT: begin
            // Refill only fills the line; the next lookup delivers it.
            if (mc_finish_fetch) begin
              state_q   <= S_IDLE;
              discard_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // A discarded fetch is by construction still outstanding.
  a_discard_only_waiting: assert property (
    @(posedge clk_in) disable iff (!rst_in) discard_q |-> (state_q == S_WAIT)
  );

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a latency-modelled memory
// controller and a scoreboard for deliveries and fetch requests.
module tb_instruction_fetcher;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        mc_fetch_start;
  logic [31:0] mc_pc;
  logic        mc_finish_fetch = 1'b0;
  logic [31:0] mc_instruction = 32'h0;
  logic        iq_full = 1'b1;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        rob_clear = 1'b0;
  logic [31:0] rob_clear_pc = 32'h0;

  instruction_fetcher dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .mc_fetch_start  (mc_fetch_start),
    .mc_pc           (mc_pc),
    .mc_finish_fetch (mc_finish_fetch),
    .mc_instruction  (mc_instruction),
    .iq_full         (iq_full),
    .iq_valid        (iq_valid),
    .iq_inst         (iq_inst),
    .iq_pc           (iq_pc),
    .rob_clear       (rob_clear),
    .rob_clear_pc    (rob_clear_pc)
  );

  always #5 clk = ~clk;

  // ref_kind: 0 no timing check, 1 cycles since accepted finish, 2 cycles since last delivery
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          ref_kind;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fin = -100;
  int last_dlv = -100;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return 32'h1300_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dlv(input logic [31:0] pc, input int kind, input int gap);
    exp_t e;
    e.inst = mem_word(pc);
    e.pc = pc;
    e.ref_kind = kind;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || req_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout pending_dlv=%0d pending_req=%0d required=0", tag, exp_q.size(), req_q.size());
    end
  endtask

  task automatic wait_fin(input int max, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mc_finish_fetch && n < max);
    if (!mc_finish_fetch) begin
      total++;
      bad++;
      $display("FAIL %s_fin_timeout actual=0 required=1", tag);
    end
  endtask

  // Memory controller model: accepts a request, answers after LAT cycles with a
  // one-cycle finish pulse, freezes with the rest of the system while !rdy_in.
  initial begin
    bit busy = 0;
    int cnt = 0;
    logic [31:0] addr = 32'h0;
    logic r, rs;
    forever begin
      @(posedge clk);
      r = rdy_in;
      rs = rst_in;
      #1;
      if (!rs) begin
        busy = 0;
        mc_finish_fetch = 1'b0;
      end else if (r) begin
        if (mc_finish_fetch) begin
          mc_finish_fetch = 1'b0;
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 0;
            mc_finish_fetch = 1'b1;
            mc_instruction = mem_word(addr);
          end
        end else if (mc_fetch_start) begin
          busy = 1;
          cnt = LAT;
          addr = mc_pc;
        end
      end
    end
  end

  // Monitor: checks every new fetch request and every consumed delivery.
  initial begin
    logic prev_start = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_in && rdy_in && mc_finish_fetch) last_fin = cyc;
      if (rst_in && mc_fetch_start && !prev_start) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_request mc_pc=%h required=none", mc_pc);
        end else begin
          chk("mc_pc", mc_pc, req_q.pop_front());
        end
      end
      prev_start = mc_fetch_start;
      if (rst_in && rdy_in && iq_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery iq_pc=%h iq_inst=%h required=none", iq_pc, iq_inst);
        end else begin
          e = exp_q.pop_front();
          chk("iq_pc", iq_pc, e.pc);
          chk("iq_inst", iq_inst, e.inst);
          if (e.ref_kind == 1) chk("lat_from_finish", 32'(cyc - last_fin), 32'(e.gap));
          if (e.ref_kind == 2) chk("gap_from_prev", 32'(cyc - last_dlv), 32'(e.gap));
        end
        last_dlv = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_iq_valid", {31'h0, iq_valid}, 32'h0);
    chk("rst_fetch_start", {31'h0, mc_fetch_start}, 32'h0);
    chk("rst_iq_inst", iq_inst, 32'h0);
    chk("rst_iq_pc", iq_pc, 32'h0);

    // Cold start and warm-up: each word misses, delivery two negedges after finish
    for (int i = 0; i < 4; i++) begin
      req_q.push_back(32'(i * 4));
      push_dlv(32'(i * 4), 1, 2);
    end
    req_q.push_back(32'h10);
    iq_full = 1'b0;
    rst_in = 1'b1;
    wait_done(200, "cold");
    iq_full = 1'b1;
    repeat (15) tick();

    // Warm streaming with backpressure: stalled at 0x10, redirect to 0
    push_dlv(32'h0, 0, 0);
    push_dlv(32'h4, 2, 1);
    push_dlv(32'h8, 2, 4);
    push_dlv(32'hC, 2, 1);
    push_dlv(32'h10, 2, 1);
    req_q.push_back(32'h14);
    rob_clear = 1'b1; rob_clear_pc = 32'h0;
    tick();
    rob_clear = 1'b0; iq_full = 1'b0;
    tick(); tick();
    iq_full = 1'b1;
    repeat (3) tick();
    iq_full = 1'b0;
    repeat (3) tick();
    iq_full = 1'b1;
    wait_done(100, "stream");
    repeat (10) tick();

    // Flush mid-miss at 0x40, redirect to 0x100 (conflicts with line 0)
    req_q.push_back(32'h40);
    req_q.push_back(32'h100);
    rob_clear = 1'b1; rob_clear_pc = 32'h40;
    tick();
    rob_clear = 1'b0;
    tick(); tick();
    rob_clear = 1'b1; rob_clear_pc = 32'h100;
    tick();
    rob_clear = 1'b0;
    wait_done(100, "flush");
    repeat (10) tick();

    // 0x40 hits without a request; 0 was evicted; clear coincident with finish
    push_dlv(32'h40, 0, 0);
    req_q.push_back(32'h0);
    req_q.push_back(32'h100);
    rob_clear = 1'b1; rob_clear_pc = 32'h40; iq_full = 1'b0;
    tick();
    rob_clear = 1'b0;
    tick();
    rob_clear = 1'b1; rob_clear_pc = 32'h0; iq_full = 1'b1;
    tick();
    rob_clear = 1'b0;
    wait_fin(50, "evict");
    #1;
    rob_clear = 1'b1; rob_clear_pc = 32'h100;
    tick();
    rob_clear = 1'b0;
    wait_done(100, "evict");
    repeat (10) tick();

    // Pause across the finish pulse, stretched iq_valid, then reset mid-miss
    push_dlv(32'h80, 1, 4);
    req_q.push_back(32'h80);
    req_q.push_back(32'h84);
    rob_clear = 1'b1; rob_clear_pc = 32'h80; iq_full = 1'b0;
    tick();
    rob_clear = 1'b0;
    wait_fin(50, "pause");
    #1;
    rdy_in = 1'b0;
    repeat (3) tick();
    rdy_in = 1'b1;
    tick(); tick();
    rdy_in = 1'b0;
    tick(); tick();
    rdy_in = 1'b1;
    wait_done(100, "pause");
    rst_in = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("mid_rst_iq_valid", {31'h0, iq_valid}, 32'h0);
    chk("mid_rst_fetch_start", {31'h0, mc_fetch_start}, 32'h0);
    req_q.push_back(32'h0);
    iq_full = 1'b1;
    rst_in = 1'b1;
    wait_done(100, "post_rst");
    repeat (10) tick();

    chk("left_deliveries", 32'(exp_q.size()), 32'h0);
    chk("left_requests", 32'(req_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
